// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO write port among NUM_REQ requesters.
// Define WR_ARB_STATS_EN to enable the saturating full-stall cycle counter on stall_cnt.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        full,
  output logic                        wr_en,
  output logic [DATA_W-1:0]           data_w,
  output logic [2:0]                  owner,
  output logic                        busy,
  output logic [15:0]                 stall_cnt
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {IDLE, BURST} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic               own_valid;
  logic [DATA_W-1:0]  own_data;
  logic [NUM_REQ-1:0] rot_valid;
  logic               found;
  logic [IDX_W-1:0]   sel;
  logic [IDX_W:0]     pos;
  logic               beat_last;

  // Owner mux, rotated round-robin search, and next-state/output decode.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    wr_en      = 1'b0;
    req_ready  = '0;
    data_w     = '0;
    own_valid  = 1'b0;
    own_data   = '0;
    found      = 1'b0;
    sel        = '0;
    pos        = '0;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_valid = req_valid[i];
        own_data  = req_data[i*DATA_W +: DATA_W];
      end
    end

    // Bit i of rot_valid is requester (rr_ptr + i) mod NUM_REQ.
    rot_valid = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot_valid[i]) begin
        found = 1'b1;
        pos   = (IDX_W+1)'(rr_ptr_q) + (IDX_W+1)'(i);
        if (pos >= (IDX_W+1)'(NUM_REQ)) pos = pos - (IDX_W+1)'(NUM_REQ);
        sel   = IDX_W'(pos);
      end
    end

    beat_last = ((CNT_W+1)'(beat_cnt_q) + (CNT_W+1)'(1)) == (CNT_W+1)'(MAX_BURST);

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BURST;
          owner_d    = sel;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        wr_en  = own_valid & ~full;
        data_w = own_data;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner_q == IDX_W'(i)) req_ready[i] = ~full;
        end
        if (wr_en) beat_cnt_d = beat_cnt_q + CNT_W'(1);
        // Release on dropped valid or on the final beat of a full-length burst.
        if (!own_valid || (wr_en && beat_last)) begin
          state_d    = IDLE;
          owner_d    = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q == BURST);

`ifdef WR_ARB_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Counts cycles where the owner wants to write but the FIFO is full.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == BURST) && own_valid && full && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed-vector bench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=8, MAX_BURST=8).
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        full;
  logic        wr_en;
  logic [7:0]  data_w;
  logic [2:0]  owner;
  logic        busy;
  logic [15:0] stall_cnt;

  int vectors;
  int miscompares;

  // Observed bundle: {wr_en, busy, owner, req_ready, data_w}
  logic [16:0] obs;
  logic [16:0] exp;
  logic [15:0] exp_stall;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .full      (full),
    .wr_en     (wr_en),
    .data_w    (data_w),
    .owner     (owner),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    full      = 1'b0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h4433_2211;
    full      = 1'b0;
    #3;
    obs = {wr_en, busy, owner, req_ready, data_w};
    exp = {1'b0, 1'b0, 3'd0, 4'b0000, 8'h00};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want %h", obs, exp);
    end
    vectors++;
    if (stall_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_stall_cnt: got %h want 0000", stall_cnt);
    end
  endtask

  task automatic test_single();
    int b;
    do_reset();
    req_valid     = 4'b0001;
    req_data[7:0] = 8'hA0;
    #1;
    obs = {wr_en, busy, owner, req_ready, data_w};
    exp = {1'b0, 1'b0, 3'd0, 4'b0000, 8'h00};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL single_idle: got %h want %h", obs, exp);
    end
    // 8 beats, one bubble, then 4 more beats.
    for (int c = 0; c < 13; c++) begin
      tick();
      b = (c < 8) ? c : c - 1;
      req_data[7:0] = 8'(8'hA0 + b);
      #1;
      obs = {wr_en, busy, owner, req_ready, data_w};
      if (c == 8) exp = {1'b0, 1'b0, 3'd0, 4'b0000, 8'h00};
      else        exp = {1'b1, 1'b1, 3'd0, 4'b0001, 8'(8'hA0 + b)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL single_cycle%0d: got %h want %h", c, obs, exp);
      end
    end
    tick();
    req_valid = 4'b0000;
    #1;
    obs = {wr_en, busy, owner, req_ready, data_w};
    exp = {1'b0, 1'b1, 3'd0, 4'b0001, 8'hAB};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL single_drop: got %h want %h", obs, exp);
    end
    tick();
    obs = {wr_en, busy, owner, req_ready, data_w};
    exp = {1'b0, 1'b0, 3'd0, 4'b0000, 8'h00};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL single_release: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_round_robin();
    int own;
    do_reset();
    req_valid = 4'b1111;
    req_data  = 32'h4433_2211;
    #1;
    for (int bu = 0; bu < 5; bu++) begin
      own = bu % 4;
      for (int k = 0; k < 8; k++) begin
        tick();
        obs = {wr_en, busy, owner, req_ready, data_w};
        exp = {1'b1, 1'b1, 3'(own), 4'(1 << own), 8'(8'h11 * (own + 1))};
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL rr_burst%0d_beat%0d: got %h want %h", bu, k, obs, exp);
        end
      end
      tick();
      obs = {wr_en, busy, owner, req_ready, data_w};
      exp = {1'b0, 1'b0, 3'd0, 4'b0000, 8'h00};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL rr_bubble%0d: got %h want %h", bu, obs, exp);
      end
    end
  endtask

  task automatic test_full_stall();
    int b;
    do_reset();
    req_valid       = 4'b0100;
    req_data[23:16] = 8'hC0;
    #1;
    for (int c = 0; c < 13; c++) begin
      tick();
      full = (c >= 3) && (c < 8);
      b = (c < 3) ? c : ((c < 8) ? 3 : c - 5);
      req_data[23:16] = 8'(8'hC0 + b);
      #1;
      obs = {wr_en, busy, owner, req_ready, data_w};
      if (full) exp = {1'b0, 1'b1, 3'd2, 4'b0000, 8'hC3};
      else      exp = {1'b1, 1'b1, 3'd2, 4'b0100, 8'(8'hC0 + b)};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: got %h want %h", c, obs, exp);
      end
    end
    tick();
    full = 1'b0;
    #1;
    obs = {wr_en, busy, owner, req_ready, data_w};
    exp = {1'b0, 1'b0, 3'd0, 4'b0000, 8'h00};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL stall_end_bubble: got %h want %h", obs, exp);
    end
`ifdef WR_ARB_STATS_EN
    exp_stall = 16'd5;
`else
    exp_stall = 16'd0;
`endif
    vectors++;
    if (stall_cnt !== exp_stall) begin
      miscompares++;
      $display("FAIL stall_count: got %h want %h", stall_cnt, exp_stall);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_early_release();
    do_reset();
    req_valid       = 4'b1010;
    req_data[15:8]  = 8'h5A;
    req_data[31:24] = 8'h7E;
    #1;
    for (int k = 0; k < 2; k++) begin
      tick();
      obs = {wr_en, busy, owner, req_ready, data_w};
      exp = {1'b1, 1'b1, 3'd1, 4'b0010, 8'h5A};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL early_beat%0d: got %h want %h", k, obs, exp);
      end
    end
    // Requester 0 also becomes valid: it must lose to 3 because rr_ptr moves to 2.
    tick();
    req_valid = 4'b1001;
    #1;
    obs = {wr_en, busy, owner, req_ready, data_w};
    exp = {1'b0, 1'b1, 3'd1, 4'b0010, 8'h5A};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL early_drop: got %h want %h", obs, exp);
    end
    tick();
    obs = {wr_en, busy, owner, req_ready, data_w};
    exp = {1'b0, 1'b0, 3'd0, 4'b0000, 8'h00};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL early_bubble: got %h want %h", obs, exp);
    end
    tick();
    obs = {wr_en, busy, owner, req_ready, data_w};
    exp = {1'b1, 1'b1, 3'd3, 4'b1000, 8'h7E};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL early_next_owner: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_valid     = 4'b0001;
    req_data[7:0] = 8'h3C;
    #1;
    for (int k = 0; k < 4; k++) begin
      tick();
      obs = {wr_en, busy, owner, req_ready, data_w};
      exp = {1'b1, 1'b1, 3'd0, 4'b0001, 8'h3C};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL rstmid_beat%0d: got %h want %h", k, obs, exp);
      end
    end
    reset = 1'b1;
    #1;
    obs = {wr_en, busy, owner, req_ready, data_w};
    exp = {1'b0, 1'b0, 3'd0, 4'b0000, 8'h00};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL rstmid_async: got %h want %h", obs, exp);
    end
    reset          = 1'b0;
    req_valid      = 4'b0010;
    req_data[15:8] = 8'h96;
    #1;
    obs = {wr_en, busy, owner, req_ready, data_w};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL rstmid_idle: got %h want %h", obs, exp);
    end
    tick();
    obs = {wr_en, busy, owner, req_ready, data_w};
    exp = {1'b1, 1'b1, 3'd1, 4'b0010, 8'h96};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL rstmid_regrant: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_drop_under_full();
    do_reset();
    req_valid = 4'b0011;
    req_data  = 32'h0000_0201;
    #1;
    tick();
    obs = {wr_en, busy, owner, req_ready, data_w};
    exp = {1'b1, 1'b1, 3'd0, 4'b0001, 8'h01};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL dropfull_beat: got %h want %h", obs, exp);
    end
    tick();
    full      = 1'b1;
    req_valid = 4'b0010;
    #1;
    obs = {wr_en, busy, owner, req_ready, data_w};
    exp = {1'b0, 1'b1, 3'd0, 4'b0000, 8'h01};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL dropfull_drop: got %h want %h", obs, exp);
    end
    tick();
    obs = {wr_en, busy, owner, req_ready, data_w};
    exp = {1'b0, 1'b0, 3'd0, 4'b0000, 8'h00};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL dropfull_bubble: got %h want %h", obs, exp);
    end
    tick();
    full = 1'b0;
    #1;
    obs = {wr_en, busy, owner, req_ready, data_w};
    exp = {1'b1, 1'b1, 3'd1, 4'b0010, 8'h02};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL dropfull_next_owner: got %h want %h", obs, exp);
    end
    // Owner not valid while full must not count as a stall.
    vectors++;
    if (stall_cnt !== 16'd0) begin
      miscompares++;
      $display("FAIL dropfull_stall_cnt: got %h want 0000", stall_cnt);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
    test_drop_under_full();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
